// File: rtl/pid_sum_sched.sv
// PID sum-stage scheduler: issues Kp*e, Ki*i, Kd*d to a shared pipelined multiplier,
// accumulates the products, rescales by the gain fraction and saturates to OW bits.
module pid_sum_sched #(
    parameter int DW   = 16,
    parameter int GW   = 16,
    parameter int FRAC = 8,
    parameter int OW   = 16,
    parameter int TMO  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sum_enable,
    input  logic [DW-1:0]        err_term,
    input  logic [DW-1:0]        int_term,
    input  logic [DW-1:0]        deriv_term,
    input  logic [GW-1:0]        kp,
    input  logic [GW-1:0]        ki,
    input  logic [GW-1:0]        kd,
    output logic [DW-1:0]        mul_a,
    output logic [GW-1:0]        mul_b,
    output logic                 mul_valid,
    input  logic [DW+GW-1:0]     mul_p,
    input  logic                 mul_pvalid,
    output logic [OW-1:0]        sum_out,
    output logic                 sum_rdy,
    output logic                 sat_flag,
    output logic                 mul_tmo,
    output logic                 busy
);

    localparam int PW = DW + GW;
    localparam int AW = DW + GW + 2;
    localparam int TW = $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_C = TW'(TMO);
    localparam logic signed [AW-1:0] SMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, LOAD, ISSUE_P, ISSUE_I, ISSUE_D, WAIT, SAT, DONE
    } state_t;

    state_t state_reg, state_next;

    logic [DW-1:0]           int_reg, deriv_reg;
    logic [GW-1:0]           ki_reg, kd_reg;
    logic [DW-1:0]           mul_a_reg;
    logic [GW-1:0]           mul_b_reg;
    logic signed [AW-1:0]    acc_reg;
    logic [1:0]              count_reg;
    logic [TW-1:0]           timer_reg;
    logic [OW-1:0]           sum_out_reg;
    logic                    sat_reg;

    logic                    issuing;
    logic                    collect;
    logic [1:0]              count_next;
    logic signed [AW-1:0]    acc_next;
    logic                    timed_out;
    logic signed [AW-1:0]    shifted;
    logic [OW-1:0]           sat_val;
    logic                    sat_hit;

    assign issuing = (state_reg == ISSUE_P) || (state_reg == ISSUE_I) || (state_reg == ISSUE_D);

    // Products are only taken while the pipeline can still owe us one.
    assign collect    = (issuing || (state_reg == WAIT)) && (count_reg != 2'd3) && mul_pvalid;
    assign count_next = count_reg + {1'b0, collect};
    assign acc_next   = acc_reg + $signed({{(AW-PW){mul_p[PW-1]}}, mul_p});

    always_comb begin
        shifted = acc_reg >>> FRAC;
        sat_val = shifted[OW-1:0];
        sat_hit = 1'b0;
        if (shifted > SMAX) begin
            sat_val = SMAX[OW-1:0];
            sat_hit = 1'b1;
        end else if (shifted < SMIN) begin
            sat_val = SMIN[OW-1:0];
            sat_hit = 1'b1;
        end
    end

    // A product landing in the timeout cycle still completes the sum.
    assign timed_out = (state_reg == WAIT) && (count_next != 2'd3) && (timer_reg == TMO_C);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (sum_enable) state_next = LOAD;
            LOAD:    state_next = ISSUE_P;
            ISSUE_P: state_next = ISSUE_I;
            ISSUE_I: state_next = ISSUE_D;
            ISSUE_D: state_next = WAIT;
            WAIT: begin
                if (count_next == 2'd3)
                    state_next = SAT;
                else if (timed_out)
                    state_next = IDLE;
            end
            SAT:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            int_reg     <= '0;
            deriv_reg   <= '0;
            ki_reg      <= '0;
            kd_reg      <= '0;
            mul_a_reg   <= '0;
            mul_b_reg   <= '0;
            acc_reg     <= '0;
            count_reg   <= '0;
            timer_reg   <= '0;
            sum_out_reg <= '0;
            sat_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                LOAD: begin
                    // The P operands go straight into the issue registers.
                    mul_a_reg <= err_term;
                    mul_b_reg <= kp;
                    int_reg   <= int_term;
                    deriv_reg <= deriv_term;
                    ki_reg    <= ki;
                    kd_reg    <= kd;
                    acc_reg   <= '0;
                    count_reg <= '0;
                    timer_reg <= '0;
                end
                ISSUE_P: begin
                    mul_a_reg <= int_reg;
                    mul_b_reg <= ki_reg;
                end
                ISSUE_I: begin
                    mul_a_reg <= deriv_reg;
                    mul_b_reg <= kd_reg;
                end
                SAT: begin
                    sum_out_reg <= sat_val;
                    sat_reg     <= sat_hit;
                end
                default: ;
            endcase
            if (issuing || (state_reg == WAIT)) begin
                timer_reg <= timer_reg + 1'b1;
            end
            if (collect) begin
                acc_reg   <= acc_next;
                count_reg <= count_next;
            end
        end
    end

    assign mul_a     = mul_a_reg;
    assign mul_b     = mul_b_reg;
    assign mul_valid = issuing;
    assign sum_out   = sum_out_reg;
    assign sat_flag  = sat_reg;
    assign sum_rdy   = (state_reg == DONE);
    assign mul_tmo   = timed_out;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_pid_sum_sched.sv
// Directed bench for pid_sum_sched with a 3-cycle pipelined multiplier model.
module tb_pid_sum_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        sum_enable = 1'b0;
    logic [15:0] err_term = '0, int_term = '0, deriv_term = '0;
    logic [15:0] kp = '0, ki = '0, kd = '0;
    logic [15:0] mul_a, mul_b;
    logic        mul_valid;
    logic [31:0] mul_p;
    logic        mul_pvalid;
    logic [15:0] sum_out;
    logic        sum_rdy, sat_flag, mul_tmo, busy;

    pid_sum_sched #(.DW(16), .GW(16), .FRAC(8), .OW(16), .TMO(64)) dut (
        .clk(clk), .rst(rst), .sum_enable(sum_enable),
        .err_term(err_term), .int_term(int_term), .deriv_term(deriv_term),
        .kp(kp), .ki(ki), .kd(kd),
        .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid),
        .mul_p(mul_p), .mul_pvalid(mul_pvalid),
        .sum_out(sum_out), .sum_rdy(sum_rdy), .sat_flag(sat_flag),
        .mul_tmo(mul_tmo), .busy(busy)
    );

    // Multiplier model: latency 3, optionally drops products past pv_limit.
    logic [2:0]  pv_pipe = '0;
    logic [31:0] pp0 = '0, pp1 = '0, pp2 = '0;
    int          issued = 0;
    int          pv_limit = 3;
    logic        clr_issued = 1'b0;
    logic        stray_pv = 1'b0;
    logic [31:0] stray_p = '0;

    always @(posedge clk) begin
        if (clr_issued) issued <= 0;
        else if (mul_valid) issued <= issued + 1;
        pv_pipe[0] <= mul_valid && (issued < pv_limit);
        pp0 <= $signed(mul_a) * $signed(mul_b);
        pv_pipe[1] <= pv_pipe[0];
        pp1 <= pp0;
        pv_pipe[2] <= pv_pipe[1];
        pp2 <= pp1;
    end

    assign mul_pvalid = pv_pipe[2] | stray_pv;
    assign mul_p      = stray_pv ? stray_p : pp2;

    int tests_run = 0;
    int fails = 0;

    logic [127:0] valid_mask, rdy_mask, tmo_mask, busy_mask;
    logic [15:0]  so_hist [0:127];
    logic [15:0]  rdy_val;
    logic         rdy_sat;

    // Cycle 0 is the cycle whose closing edge samples sum_enable=1.
    task automatic run(input logic [15:0] e, i, d, gp, gi_, gd,
                       input int n, input int en2, input int rcyc);
        err_term = e; int_term = i; deriv_term = d;
        kp = gp; ki = gi_; kd = gd;
        clr_issued = 1'b1;
        @(posedge clk); #1;
        clr_issued = 1'b0;
        valid_mask = '0; rdy_mask = '0; tmo_mask = '0; busy_mask = '0;
        rdy_val = 16'hDEAD; rdy_sat = 1'bx;
        for (int k = 0; k < n; k++) begin
            sum_enable = (k == 0) || (k == en2);
            rst = (k == rcyc);
            @(negedge clk);
            valid_mask[k] = mul_valid;
            rdy_mask[k]   = sum_rdy;
            tmo_mask[k]   = mul_tmo;
            busy_mask[k]  = busy;
            so_hist[k]    = sum_out;
            if (sum_rdy) begin
                rdy_val = sum_out;
                rdy_sat = sat_flag;
            end
            @(posedge clk); #1;
        end
        sum_enable = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests_run++; if (sum_out !== 16'h0) begin $display("FAIL reset_sum_out: got %0h want 0", sum_out); fails++; end
        tests_run++; if (sat_flag !== 1'b0) begin $display("FAIL reset_sat: got %0b want 0", sat_flag); fails++; end
        tests_run++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %0b want 0", busy); fails++; end
        tests_run++; if ({mul_valid, sum_rdy, mul_tmo} !== 3'b000) begin $display("FAIL reset_pulses: got %0b want 000", {mul_valid, sum_rdy, mul_tmo}); fails++; end
        tests_run++; if ({mul_a, mul_b} !== 32'h0) begin $display("FAIL reset_mul_ab: got %0h want 0", {mul_a, mul_b}); fails++; end
    endtask

    task automatic test_nominal;
        run(16'd100, 16'd40, -16'sd10, 16'h0100, 16'h0080, 16'h0200, 14, -1, -1);
        tests_run++; if (valid_mask !== 128'h1C) begin $display("FAIL nom_valid_cycles: got %0h want 1c", valid_mask); fails++; end
        tests_run++; if (rdy_mask !== 128'h200) begin $display("FAIL nom_rdy_cycles: got %0h want 200", rdy_mask); fails++; end
        tests_run++; if (rdy_val !== 16'd100) begin $display("FAIL nom_sum: got %0d want 100", rdy_val); fails++; end
        tests_run++; if (rdy_sat !== 1'b0) begin $display("FAIL nom_sat: got %0b want 0", rdy_sat); fails++; end
        tests_run++; if (busy_mask[10:0] !== 11'h3FE) begin $display("FAIL nom_busy: got %0h want 3fe", busy_mask[10:0]); fails++; end
        tests_run++; if (tmo_mask !== 128'h0) begin $display("FAIL nom_tmo: got %0h want 0", tmo_mask); fails++; end
    endtask

    task automatic test_pos_sat;
        run(16'h7FFF, 16'd0, 16'd0, 16'h7FFF, 16'h0, 16'h0, 14, -1, -1);
        tests_run++; if (rdy_val !== 16'h7FFF) begin $display("FAIL pos_sat_sum: got %0h want 7fff", rdy_val); fails++; end
        tests_run++; if (rdy_sat !== 1'b1) begin $display("FAIL pos_sat_flag: got %0b want 1", rdy_sat); fails++; end
    endtask

    task automatic test_neg_sat;
        run(16'h8000, 16'd0, 16'd0, 16'h7FFF, 16'h0, 16'h0, 14, -1, -1);
        tests_run++; if (rdy_val !== 16'h8000) begin $display("FAIL neg_sat_sum: got %0h want 8000", rdy_val); fails++; end
        tests_run++; if (rdy_sat !== 1'b1) begin $display("FAIL neg_sat_flag: got %0b want 1", rdy_sat); fails++; end
        run(16'hFFFF, 16'd0, 16'd0, 16'h0001, 16'h0, 16'h0, 14, -1, -1);
        tests_run++; if (rdy_val !== 16'hFFFF) begin $display("FAIL floor_sum: got %0h want ffff", rdy_val); fails++; end
        tests_run++; if (rdy_sat !== 1'b0) begin $display("FAIL floor_sat: got %0b want 0", rdy_sat); fails++; end
    endtask

    task automatic test_timeout;
        pv_limit = 2;
        run(16'd100, 16'd40, 16'd10, 16'h0100, 16'h0100, 16'h0100, 80, -1, -1);
        pv_limit = 3;
        tests_run++; if (tmo_mask !== (128'h1 << 66)) begin $display("FAIL tmo_cycle: got %0h want bit 66", tmo_mask); fails++; end
        tests_run++; if (rdy_mask !== 128'h0) begin $display("FAIL tmo_no_rdy: got %0h want 0", rdy_mask); fails++; end
        tests_run++; if (busy_mask[67:66] !== 2'b01) begin $display("FAIL tmo_busy: got %0b want 01", busy_mask[67:66]); fails++; end
        tests_run++; if (so_hist[79] !== 16'hFFFF) begin $display("FAIL tmo_sum_held: got %0h want ffff", so_hist[79]); fails++; end
    endtask

    task automatic test_busy_ignore;
        run(16'd100, 16'd40, -16'sd10, 16'h0100, 16'h0080, 16'h0200, 16, 3, -1);
        tests_run++; if (rdy_mask !== 128'h200) begin $display("FAIL busy_one_rdy: got %0h want 200", rdy_mask); fails++; end
        tests_run++; if (valid_mask !== 128'h1C) begin $display("FAIL busy_valid: got %0h want 1c", valid_mask); fails++; end
    endtask

    task automatic test_stray_pvalid;
        stray_p = 32'h7FFF_0000;
        stray_pv = 1'b1;
        @(posedge clk); #1;
        stray_pv = 1'b0;
        run(16'd100, 16'd40, -16'sd10, 16'h0100, 16'h0080, 16'h0200, 14, -1, -1);
        tests_run++; if (rdy_val !== 16'd100) begin $display("FAIL stray_sum: got %0d want 100", rdy_val); fails++; end
        tests_run++; if (rdy_sat !== 1'b0) begin $display("FAIL stray_sat: got %0b want 0", rdy_sat); fails++; end
    endtask

    task automatic test_reset_mid;
        run(16'd100, 16'd40, -16'sd10, 16'h0100, 16'h0080, 16'h0200, 20, -1, 5);
        tests_run++; if (busy_mask[6:5] !== 2'b01) begin $display("FAIL rstmid_busy: got %0b want 01", busy_mask[6:5]); fails++; end
        tests_run++; if (so_hist[6] !== 16'h0) begin $display("FAIL rstmid_sum: got %0h want 0", so_hist[6]); fails++; end
        tests_run++; if (rdy_mask !== 128'h0) begin $display("FAIL rstmid_no_rdy: got %0h want 0", rdy_mask); fails++; end
        tests_run++; if (tmo_mask !== 128'h0) begin $display("FAIL rstmid_no_tmo: got %0h want 0", tmo_mask); fails++; end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_pos_sat;
        test_neg_sat;
        test_timeout;
        test_busy_ignore;
        test_stray_pvalid;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
